// File: rtl/program_loader.sv
// program_loader
//   Writer side of the instruction memory. Accepts a framed byte stream
//   (LEN, hi/lo instruction byte pairs, CHK) over valid/ready, assembles
//   16-bit instructions MSB first and writes them sequentially from address 0.
//   The processor is held (cpu_hold) until an image with a correct XOR
//   checksum has been written completely.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      single-cycle pulse that begins a load (ignored while busy)
//   in_valid   input byte valid
//   in_data    input byte
//   in_ready   loader accepts a byte this cycle (registered, state only)
//   mem_we     program RAM write enable, one cycle per instruction
//   mem_addr   program RAM write address
//   mem_wdata  instruction word {hi_byte, lo_byte}
//   cpu_hold   1 = processor held
//   busy       frame in progress
//   done       sticky: last load succeeded
//   err        sticky: last load failed
//
// State | meaning
//   IDLE  | no load since reset, waiting for start
//   LEN   | waiting for the instruction count byte
//   HI    | waiting for the high byte of an instruction
//   LO    | waiting for the low byte; write issued the cycle after
//   CHK   | waiting for the checksum byte
//   DONE  | image loaded and verified, processor released
//   ERR   | bad length, bad checksum or timeout; processor stays held

module program_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_wdata,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int         TW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [9:0] DEPTH = 10'(1 << ADDR_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_HI,
        S_LO,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t                state, state_nxt;
    logic [7:0]            checksum;
    logic [8:0]            remaining;
    logic [7:0]            hi_byte;
    logic [ADDR_WIDTH-1:0] addr;
    logic [TW-1:0]         idle_cnt;

    logic xfer;
    logic busy_state;
    logic busy_nxt;
    logic start_load;
    logic len_bad;
    logic timeout;

    assign xfer       = in_valid && in_ready;
    assign busy_state = (state == S_LEN) || (state == S_HI) ||
                        (state == S_LO)  || (state == S_CHK);
    assign busy_nxt   = (state_nxt == S_LEN) || (state_nxt == S_HI) ||
                        (state_nxt == S_LO)  || (state_nxt == S_CHK);
    assign start_load = start && !busy_state;

    // LEN=0 means 256 instructions, which only fits a full 8-bit address space
    assign len_bad = (in_data == 8'd0) ? (ADDR_WIDTH < 8)
                                       : ({2'b00, in_data} > DEPTH);

    // idle_cnt counts idle cycles already elapsed; this cycle would be number TIMEOUT
    assign timeout = busy_state && !xfer && (idle_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) state_nxt = S_LEN;
            end
            S_LEN: begin
                if (xfer) state_nxt = len_bad ? S_ERR : S_HI;
            end
            S_HI: begin
                if (xfer) state_nxt = S_LO;
            end
            S_LO: begin
                if (xfer) state_nxt = (remaining == 9'd1) ? S_CHK : S_HI;
            end
            S_CHK: begin
                if (xfer) state_nxt = (in_data == checksum) ? S_DONE : S_ERR;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (timeout) state_nxt = S_ERR;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_hold  <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            checksum  <= '0;
            remaining <= '0;
            hi_byte   <= '0;
            addr      <= '0;
            idle_cnt  <= '0;
        end else begin
            in_ready <= busy_nxt;
            busy     <= busy_nxt;
            mem_we   <= 1'b0;

            if (start_load) begin
                done     <= 1'b0;
                err      <= 1'b0;
                cpu_hold <= 1'b1;
                checksum <= '0;
                addr     <= '0;
            end

            if (!busy_nxt || xfer) begin
                idle_cnt <= '0;
            end else if (busy_state) begin
                idle_cnt <= idle_cnt + TW'(1);
            end

            if (xfer) begin
                case (state)
                    S_LEN: begin
                        checksum  <= checksum ^ in_data;
                        remaining <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
                    end
                    S_HI: begin
                        checksum <= checksum ^ in_data;
                        hi_byte  <= in_data;
                    end
                    S_LO: begin
                        checksum  <= checksum ^ in_data;
                        remaining <= remaining - 9'd1;
                        mem_we    <= 1'b1;
                        mem_addr  <= addr;
                        mem_wdata <= {hi_byte, in_data};
                        addr      <= addr + ADDR_WIDTH'(1);
                    end
                    default: ;
                endcase
            end

            if (state == S_CHK && state_nxt == S_DONE) begin
                done     <= 1'b1;
                cpu_hold <= 1'b0;
            end
            if (busy_state && state_nxt == S_ERR) begin
                err <= 1'b1;
            end
        end
    end

endmodule
